// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace capture buffer.
// TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to every stored entry.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  // Field layout for the default 32-bit PC build; the RTL itself uses flat vectors.
  localparam int TRACE_XLEN = 32;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]           stamp;
`endif
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
  } trace_entry_t;

  function automatic int entry_w(input int xlen);
`ifdef TRACE_TIMESTAMP_EN
    return xlen + 64;
`else
    return xlen + 32;
`endif
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: synchronous write, combinational read, no reset on contents.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular capture of retired {pc, instr} pairs, frozen by a PC trigger plus post count,
// then drained oldest-first. Optional cycle stamp under TRACE_TIMESTAMP_EN.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int EW       = entry_w(XLEN),
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            arm_i,
  input  logic [XLEN-1:0] trig_pc_i,
  output logic            armed_o,
  output logic            done_o,
  output logic            trig_hit_o,
  output logic [CW-1:0]   count_o,
  output logic            rd_valid_o,
  input  logic            rd_ready_i,
  output logic [EW-1:0]   rd_data_o
);

  trace_state_e  state, state_nx;
  logic [AW-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx, post_cnt, post_cnt_nx;
  logic [CW-1:0] count, count_nx;
  logic          we, hit_nx, trig_hit, rd_fire;
  logic [EW-1:0] wr_data, rd_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] stamp;
  always_ff @(posedge clk) begin
    if (rst) stamp <= '0;
    else     stamp <= stamp + 32'd1;
  end
  assign wr_data = {stamp, pc_i, instr_i};
`else
  assign wr_data = {pc_i, instr_i};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      trig_hit <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      post_cnt <= post_cnt_nx;
      trig_hit <= hit_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    count_nx    = count;
    post_cnt_nx = post_cnt;
    we          = 1'b0;
    hit_nx      = 1'b0;
    rd_fire     = (state == DONE) && (count != '0) && rd_ready_i;
    case (state)
      IDLE: begin
        if (arm_i) begin
          state_nx  = ARMED;
          wr_ptr_nx = '0;
          count_nx  = '0;
        end
      end
      ARMED, POST: begin
        if (arm_i) begin
          state_nx  = ARMED;
          wr_ptr_nx = '0;
          count_nx  = '0;
        end else if (valid_i) begin
          we        = 1'b1;
          wr_ptr_nx = wr_ptr + AW'(1);
          if (count != CW'(DEPTH)) count_nx = count + CW'(1);
          if (state == ARMED && pc_i == trig_pc_i) begin
            hit_nx = 1'b1;
            if (POST_TRIG == 0) begin
              state_nx = DONE;
            end else begin
              state_nx    = POST;
              post_cnt_nx = AW'(POST_TRIG);
            end
          end else if (state == POST) begin
            post_cnt_nx = post_cnt - AW'(1);
            if (post_cnt == AW'(1)) state_nx = DONE;
          end
          // Oldest entry sits at the next write slot only once the buffer has wrapped.
          if (state_nx == DONE) rd_ptr_nx = (count_nx == CW'(DEPTH)) ? wr_ptr_nx : '0;
        end
      end
      DONE: begin
        if (rd_fire) begin
          rd_ptr_nx = rd_ptr + AW'(1);
          count_nx  = count - CW'(1);
          if (count == CW'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_q)
  );

  // Valid/ready: an entry transfers on any cycle with rd_valid_o && rd_ready_i;
  // rd_data_o holds while rd_valid_o && !rd_ready_i and reads as 0 otherwise.
  assign armed_o    = (state == ARMED) || (state == POST);
  assign done_o     = (state == DONE);
  assign trig_hit_o = trig_hit;
  assign count_o    = count;
  assign rd_valid_o = (state == DONE) && (count != '0);
  assign rd_data_o  = rd_valid_o ? rd_q : '0;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomized bench for trace_capture_buffer against a queue-based history model.
// Two instances: POST_TRIG=3 (main) and POST_TRIG=0 (immediate freeze).
module tb_trace_capture_buffer;
  import trace_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int EW    = entry_w(XLEN);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = XLEN + 32;

  logic            clk = 1'b0;
  logic            rst, valid_i, arm_i, rd_ready_i;
  logic [XLEN-1:0] pc_i, trig_pc_i;
  logic [31:0]     instr_i;

  logic          armed_a, done_a, hit_a, rd_valid_a;
  logic [CW-1:0] count_a;
  logic [EW-1:0] rd_data_a;
  logic          armed_b, done_b, hit_b, rd_valid_b;
  logic [CW-1:0] count_b;
  logic [EW-1:0] rd_data_b;

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(3)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .arm_i(arm_i), .trig_pc_i(trig_pc_i), .armed_o(armed_a), .done_o(done_a),
    .trig_hit_o(hit_a), .count_o(count_a), .rd_valid_o(rd_valid_a),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_a)
  );

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .arm_i(arm_i), .trig_pc_i(trig_pc_i), .armed_o(armed_b), .done_o(done_b),
    .trig_hit_o(hit_b), .count_o(count_b), .rd_valid_o(rd_valid_b),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: capture history (oldest first), mode 0 idle / 1 armed / 2 post / 3 frozen.
  logic [W-1:0] exp_q[$];
  int m_mode = 0;
  int m_post = 0;
  int m_pt   = 3;
  logic m_hit = 1'b0;

  task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic a,
                      input logic rdy, input logic r);
    valid_i = v; pc_i = pc; instr_i = $urandom; arm_i = a; rd_ready_i = rdy; rst = r;
    m_hit = 1'b0;
    if (r) begin
      m_mode = 0; exp_q.delete();
    end else if (m_mode == 3) begin
      if (rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_mode = 0;
      end
    end else if (a) begin
      m_mode = 1; exp_q.delete();
    end else if (m_mode != 0 && v) begin
      exp_q.push_back({pc, instr_i});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      if (m_mode == 1 && pc == trig_pc_i) begin
        m_hit = 1'b1; m_post = m_pt; m_mode = (m_pt == 0) ? 3 : 2;
      end else if (m_mode == 2) begin
        m_post--;
        if (m_post == 0) m_mode = 3;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(1'b1, '0, 1'b1, 1'b1, 1'b1);
    n_checks += 6;
    if (armed_a !== 1'b0)   begin n_fail++; $display("FAIL reset_armed got %b want 0", armed_a); end
    if (done_a !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
    if (hit_a !== 1'b0)     begin n_fail++; $display("FAIL reset_hit got %b want 0", hit_a); end
    if (count_a !== '0)     begin n_fail++; $display("FAIL reset_count got %0d want 0", count_a); end
    if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_a); end
    if (rd_data_a !== '0)   begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data_a); end
  endtask

  // Capture PCs 0,4,.. up to last_pc with the given trigger, then drain and compare.
  task automatic run_linear(input string name, input logic [XLEN-1:0] trig,
                            input int last_pc, input int exp_cnt, input int first_pc);
    int hits = 0;
    int k = 0;
    trig_pc_i = trig;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int pc = 0; pc <= last_pc; pc += 4) begin
      step(1'b1, XLEN'(pc), 1'b0, 1'b0, 1'b0);
      if (hit_a) hits++;
      n_checks += 3;
      if (hit_a !== m_hit) begin n_fail++; $display("FAIL %s_hit pc=%h got %b want %b", name, pc, hit_a, m_hit); end
      if (int'(count_a) !== exp_q.size()) begin n_fail++; $display("FAIL %s_count pc=%h got %0d want %0d", name, pc, count_a, exp_q.size()); end
      if (done_a !== (m_mode == 3)) begin n_fail++; $display("FAIL %s_done pc=%h got %b want %b", name, pc, done_a, m_mode == 3); end
    end
    n_checks += 3;
    if (done_a !== 1'b1) begin n_fail++; $display("FAIL %s_frozen got %b want 1", name, done_a); end
    if (int'(count_a) !== exp_cnt) begin n_fail++; $display("FAIL %s_final_count got %0d want %0d", name, count_a, exp_cnt); end
    if (hits !== 1) begin n_fail++; $display("FAIL %s_hit_pulses got %0d want 1", name, hits); end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      n_checks += 3;
      if (rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL %s_rd_valid i=%0d got %b want 1", name, i, rd_valid_a); end
      if (rd_data_a[W-1:0] !== exp_q[0]) begin n_fail++; $display("FAIL %s_rd_data i=%0d got %h want %h", name, i, rd_data_a[W-1:0], exp_q[0]); end
      if (rd_data_a[W-1:32] !== XLEN'(first_pc + 4 * k)) begin n_fail++; $display("FAIL %s_rd_pc i=%0d got %h want %h", name, i, rd_data_a[W-1:32], first_pc + 4 * k); end
      k++;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    n_checks += 4;
    if (k !== exp_cnt) begin n_fail++; $display("FAIL %s_drained got %0d want %0d", name, k, exp_cnt); end
    if (done_a !== 1'b0 || armed_a !== 1'b0) begin n_fail++; $display("FAIL %s_idle got done=%b armed=%b want 0 0", name, done_a, armed_a); end
    if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL %s_empty_valid got %b want 0", name, rd_valid_a); end
    if (count_a !== '0) begin n_fail++; $display("FAIL %s_empty_count got %0d want 0", name, count_a); end
  endtask

  task automatic test_wrap();
    run_linear("wrap", 32'h14, 32'h20, 8, 32'h04);
  endtask

  task automatic test_no_wrap();
    run_linear("nowrap", 32'h08, 32'h14, 6, 32'h00);
  endtask

  task automatic test_gaps_backpressure();
    logic [EW-1:0] held;
    int n_pre = $urandom_range(4, 12);
    int sent = 0;
    int guard = 0;
    trig_pc_i = 32'hFFFF_FFF0;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    while (m_mode != 3 && guard < 200) begin
      logic v = ($urandom_range(0, 2) != 0);
      logic [XLEN-1:0] pc = (sent == n_pre) ? trig_pc_i : ($urandom & 32'h0FFF_FFFC);
      step(v, pc, 1'b0, 1'b0, 1'b0);
      if (v) sent++;
      guard++;
      n_checks += 2;
      if (int'(count_a) !== exp_q.size()) begin n_fail++; $display("FAIL gap_count v=%b got %0d want %0d", v, count_a, exp_q.size()); end
      if (hit_a !== m_hit) begin n_fail++; $display("FAIL gap_hit got %b want %b", hit_a, m_hit); end
    end
    n_checks++;
    if (done_a !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b want 1", done_a); end
    held = rd_data_a;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, trig_pc_i, 1'b1, 1'b0, 1'b0);
      n_checks += 3;
      if (rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_valid i=%0d got %b want 1", i, rd_valid_a); end
      if (rd_data_a[W-1:0] !== exp_q[0]) begin n_fail++; $display("FAIL bp_oldest i=%0d got %h want %h", i, rd_data_a[W-1:0], exp_q[0]); end
      if (rd_data_a !== held) begin n_fail++; $display("FAIL bp_stable i=%0d got %h want %h", i, rd_data_a, held); end
    end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      n_checks++;
      if (rd_data_a[W-1:0] !== exp_q[0]) begin n_fail++; $display("FAIL gap_drain i=%0d got %h want %h", i, rd_data_a[W-1:0], exp_q[0]); end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (rd_valid_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL gap_idle got valid=%b done=%b want 0 0", rd_valid_a, done_a); end
  endtask

  task automatic test_reset_mid_post();
    trig_pc_i = 32'h14;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int pc = 0; pc <= 32'h1c; pc += 4) step(1'b1, XLEN'(pc), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (armed_a !== 1'b1) begin n_fail++; $display("FAIL midpost_armed got %b want 1", armed_a); end
    step(1'b1, 32'h20, 1'b1, 1'b1, 1'b1);
    n_checks += 5;
    if (armed_a !== 1'b0)    begin n_fail++; $display("FAIL midpost_rst_armed got %b want 0", armed_a); end
    if (done_a !== 1'b0)     begin n_fail++; $display("FAIL midpost_rst_done got %b want 0", done_a); end
    if (count_a !== '0)      begin n_fail++; $display("FAIL midpost_rst_count got %0d want 0", count_a); end
    if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL midpost_rst_valid got %b want 0", rd_valid_a); end
    if (rd_data_a !== '0 || hit_a !== 1'b0) begin n_fail++; $display("FAIL midpost_rst_data got %h/%b want 0/0", rd_data_a, hit_a); end
    test_wrap();
  endtask

  task automatic test_post_trig_zero();
    m_pt = 0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    trig_pc_i = 32'h108;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, XLEN'(32'h100 + 4 * i), 1'b0, 1'b0, 1'b0);
      n_checks += 2;
      if (done_b !== (m_mode == 3)) begin n_fail++; $display("FAIL pt0_done i=%0d got %b want %b", i, done_b, m_mode == 3); end
      if (hit_b !== m_hit) begin n_fail++; $display("FAIL pt0_hit i=%0d got %b want %b", i, hit_b, m_hit); end
    end
    n_checks += 2;
    if (done_b !== 1'b1) begin n_fail++; $display("FAIL pt0_frozen got %b want 1", done_b); end
    if (count_b !== CW'(3)) begin n_fail++; $display("FAIL pt0_count got %0d want 3", count_b); end
    for (int i = 0; i < DEPTH && exp_q.size() > 0; i++) begin
      n_checks++;
      if (rd_data_b[W-1:0] !== exp_q[0]) begin n_fail++; $display("FAIL pt0_drain i=%0d got %h want %h", i, rd_data_b[W-1:0], exp_q[0]); end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (done_b !== 1'b0 || rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL pt0_idle got done=%b valid=%b want 0 0", done_b, rd_valid_b); end
    m_pt = 3;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    trace_entry_t e;
    logic [31:0] prev = '0;
    trig_pc_i = 32'h2010;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, XLEN'(32'h2000 + 4 * i), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_a !== 1'b1) begin n_fail++; $display("FAIL ts_done got %b want 1", done_a); end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      e = rd_data_a;
      n_checks++;
      if ({e.pc, e.instr} !== exp_q[0]) begin n_fail++; $display("FAIL ts_entry i=%0d got %h want %h", i, {e.pc, e.instr}, exp_q[0]); end
      if (i > 0) begin
        n_checks++;
        if (e.stamp !== prev + 32'd1) begin n_fail++; $display("FAIL ts_delta i=%0d got %h want %h", i, e.stamp, prev + 32'd1); end
      end
      prev = e.stamp;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; valid_i = 1'b0; arm_i = 1'b0; rd_ready_i = 1'b0;
    pc_i = '0; instr_i = '0; trig_pc_i = '0;
    test_reset();
    test_wrap();
    test_no_wrap();
    test_gaps_backpressure();
    test_reset_mid_post();
    test_post_trig_zero();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Synthesizable successor to the simulation-only PC/instruction monitor on `single_cycle_cpu.debug_out`. It captures retired `{PC, instruction}` pairs into a circular buffer whose width and depth are set by parameters. A programmable PC-match trigger plus a post-trigger count freeze the buffer. The captured history is then drained oldest-first over a valid/ready port. It sits beside the core and is fed directly from the debug bus.

## Interface
- `XLEN`, 32: PC width in bits; instruction field is fixed at 32 bits.
- `DEPTH`, 16: number of entries; power of two, at least 4.
- `POST_TRIG`, 4: entries captured after the trigger entry; range 0..DEPTH-1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  `pc_i`/`instr_i` carry a retired instruction this cycle.
- `pc_i`  in  XLEN  program counter.
- `instr_i`  in  32  instruction word.
- `arm_i`  in  1  start a capture; level is sampled each cycle.
- `trig_pc_i`  in  XLEN  PC value that fires the trigger.
- `armed_o`  out  1  state is ARMED or POST.
- `done_o`  out  1  state is DONE; buffer is frozen.
- `trig_hit_o`  out  1  one-cycle pulse, the cycle after the trigger entry is written.
- `count_o`  out  $clog2(DEPTH)+1  valid entries held; saturates at DEPTH.
- `rd_valid_o`  out  1  `rd_data_o` holds an unread entry.
- `rd_ready_i`  in  1  consumer accepts the entry.
- `rd_data_o`  out  ENTRY_W  entry `{[stamp], pc, instr}`, with instr in the LSBs.

## Operation
- The FSM has four states: IDLE, ARMED, POST, DONE. Reset enters IDLE.
- On reset, all outputs are 0: pointers, `count_o` and `post_cnt` clear. RAM contents are don't-care.
- IDLE: no writes occur. `arm_i` moves the FSM to ARMED and clears `wr_ptr` and `count_o`.
- ARMED: each `valid_i` writes at `wr_ptr`, then `wr_ptr` advances modulo DEPTH and `count_o` increments up to DEPTH. Older entries are overwritten on wrap.
- Trigger condition is `valid_i && pc_i == trig_pc_i` while in ARMED. The trigger entry is itself written.
  - If POST_TRIG is 0, go to DONE.
  - Otherwise go to POST with `post_cnt = POST_TRIG`.
- POST: each `valid_i` writes an entry and decrements `post_cnt`. The write that takes `post_cnt` to 0 also moves the FSM to DONE. PC matches are ignored.
- `arm_i` while in ARMED or POST restarts the capture, with the same effect as from IDLE.
- DONE: `arm_i` and `valid_i` are ignored. `rd_ptr` is the oldest entry: 0 if `count_o < DEPTH`, else `wr_ptr`.
  - `rd_valid_o` is 1 while entries remain unread.
  - Each cycle with `rd_valid_o && rd_ready_i` advances `rd_ptr` modulo DEPTH and decrements `count_o`.
  - The transfer that takes `count_o` to 0 returns the FSM to IDLE.
- `valid_i` low writes nothing, and no counter moves.

## Timing
- `arm_i` at edge N puts the FSM in ARMED after edge N. The first capturable `valid_i` is in cycle N+1.
- Write latency: data at edge N is in RAM after edge N.
- `done_o` rises on the edge that writes the final entry.
- Read port: RAM read is combinational from `rd_ptr`. `rd_data_o` is valid in the same cycle as `rd_valid_o`. It must stay stable while `rd_valid_o && !rd_ready_i`.
- Throughput: one entry per cycle for both capture and drain.
- `rst` has priority over every other input in the same cycle.

## Configuration
- Macro `TRACE_TIMESTAMP_EN`.
- Defined: a free-running 32-bit cycle counter (cleared by `rst`, wraps at 2^32) is stored with each entry. ENTRY_W = XLEN+64, with the stamp in the MSBs.
- Not defined: there is no counter and ENTRY_W = XLEN+32.

## Structure
- Package `trace_pkg` holds:
  - the `trace_state_e` enum (IDLE, ARMED, POST, DONE);
  - the `trace_entry_t` packed struct, gated by `TRACE_TIMESTAMP_EN`;
  - the `ENTRY_W` function.
- Sub-module `trace_ram`: DEPTH×ENTRY_W storage with synchronous write and combinational read.
- The FSM, pointers and counters live in the top module.

## Test plan
All scenarios use DEPTH=8 and POST_TRIG=3 unless noted.
- Wrap: arm, then feed PCs 0x00..0x20 in steps of 4 with `trig_pc_i`=0x14.
  - `trig_hit_o` pulses once.
  - `done_o` is set after 0x20 and `count_o`=8.
  - Drain with `rd_ready_i`=1 yields 0x04,0x08,…,0x20, then the FSM is in IDLE.
- No wrap: same setup with `trig_pc_i`=0x08.
  - DONE after 0x14 with `count_o`=6.
  - Drain yields 0x00..0x14.
- Gaps and backpressure: insert `valid_i`=0 gaps; entries are unchanged and `count_o` does not move during gaps. Then hold `rd_ready_i`=0 for 5 cycles: `rd_data_o` stays fixed at the oldest entry.
- Reset mid-POST: assert `rst` after 2 post-trigger entries.
  - The next cycle shows all outputs 0.
  - Re-arm followed by a full capture behaves as in the wrap scenario.
- POST_TRIG=0, with the trigger on the 3rd entry: `done_o` rises on that write and `count_o`=3.
- With `TRACE_TIMESTAMP_EN` defined, feed back-to-back `valid_i`: the stamps of consecutive drained entries differ by exactly 1.
